sc_sched: RTL



---
 rtl/sc_sched_pkg.sv | 23 ++
 rtl/sched_ctz.sv | 24 ++
 rtl/sc_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sc_sched_pkg.sv
// Shared constants for the SC schedule controller: FSM encoding and PE op flags.
// No logic; imported by sc_sched and sched_ctz.
// Op flag values match the PE 'flag' input (1 = f, 0 = g).
package sc_sched_pkg;

    // Internal LLR word length used by the LLR memory and PE datapath.
    localparam int LLR_INTERNAL_LEN = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam logic F_OP = 1'b1;
    localparam logic G_OP = 1'b0;

    // Width of the stage field; never narrower than one bit.
    function automatic int stage_w(input int log_n);
        return (log_n > 1) ? $clog2(log_n) : 1;
    endfunction

endpackage

// File: rtl/sched_ctz.sv
// Trailing-zero encoder selecting the start stage of a new leaf.
// Latency: combinational.
// Backpressure: none (pure function); an all-zero input returns W-1 (root stage).
module sched_ctz
    import sc_sched_pkg::*;
#(
    parameter int W  = 4,
    parameter int OW = 2
) (
    input  logic [W-1:0]  i_val,
    output logic [OW-1:0] o_ctz
);

    // Scan from MSB down so the lowest set bit is the last one written.
    always_comb begin
        o_ctz = OW'(W - 1);
        for (int k = W - 1; k >= 0; k--) begin
            if (i_val[k]) begin
                o_ctz = OW'(k);
            end
        end
    end

endmodule

// File: rtl/sc_sched.sv
// SC-decoder schedule controller: walks the SC tree and issues one PE command per beat.
// Latency: first command one cycle after start; done one cycle after the last command.
// Backpressure: i_hold freezes all state and outputs. Optional macro: SC_SCHED_RATE0_EN.
module sc_sched
    import sc_sched_pkg::*;
#(
    parameter  int LOG_N = 4,
    parameter  int P     = 8,
    localparam int N     = 1 << LOG_N,
    localparam int SW    = stage_w(LOG_N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [N-1:0]     i_frozen_mask,
    input  logic             i_hold,
    output logic             o_busy,
    output logic             o_op_valid,
    output logic             o_op_f,
    output logic [SW-1:0]    o_op_stage,
    output logic [LOG_N-1:0] o_op_node,
    output logic [LOG_N-1:0] o_op_beat,
    output logic             o_leaf_valid,
    output logic [LOG_N-1:0] o_leaf_idx,
    output logic             o_rate0_valid,
    output logic [LOG_N:0]   o_rate0_len,
    output logic             o_done
);

    localparam int               LOG_P     = $clog2(P);
    localparam logic [LOG_N-1:0] LAST_LEAF = '1;
    localparam logic [LOG_N:0]   N_FULL    = {1'b1, {LOG_N{1'b0}}};
    localparam logic [LOG_N:0]   LEN_ONE   = {{LOG_N{1'b0}}, 1'b1};

    sched_state_t     r_state, w_state_nxt;
    logic             r_busy, r_op_valid, r_op_f, r_leaf_valid, r_rate0_valid, r_done;
    logic [SW-1:0]    r_op_stage;
    logic [LOG_N-1:0] r_op_node, r_op_beat, r_bcnt, r_leaf_idx;
    logic [LOG_N:0]   r_rate0_len;

    // Candidate next position in the tree walk (before any subtree skip).
    logic             w_have, w_pnew, w_pend, w_pf;
    logic [LOG_N-1:0] w_pi, w_pbcnt;
    logic [SW-1:0]    w_ps;

    // Helpers derived from the current command.
    logic [LOG_N-1:0] w_span, w_nbm1, w_ctz_in;
    logic [SW-1:0]    w_ctz;
    logic [LOG_N:0]   w_skip_nxt;
    logic             w_last_beat, w_skip_end;

    // Registered-output next values.
    logic             w_skip, w_root_ones, w_sub_ones;
    logic [LOG_N:0]   w_skip_len;
    logic             w_op_valid_nxt, w_op_f_nxt, w_leaf_valid_nxt;
    logic [SW-1:0]    w_op_stage_nxt;
    logic [LOG_N-1:0] w_op_node_nxt, w_op_beat_nxt, w_leaf_idx_nxt;

    // An op at stage s spans 2^s outputs spread over max(1, 2^s/P) beats.
    assign w_span      = LOG_N'(1) << r_op_stage;
    assign w_nbm1      = ((w_span >> LOG_P) == '0) ? '0 : (w_span >> LOG_P) - LOG_N'(1);
    assign w_last_beat = (r_bcnt == w_nbm1);

    // After a skipped subtree the walk resumes at leaf_idx + len.
    assign w_skip_nxt = {1'b0, r_leaf_idx} + r_rate0_len;
    assign w_skip_end = (w_skip_nxt == N_FULL);
    assign w_ctz_in   = r_rate0_valid ? w_skip_nxt[LOG_N-1:0] : r_leaf_idx + LOG_N'(1);

    sched_ctz #(
        .W  (LOG_N),
        .OW (SW)
    ) u_ctz (
        .i_val (w_ctz_in),
        .o_ctz (w_ctz)
    );

`ifdef SC_SCHED_RATE0_EN
    logic [N-1:0] r_mask, w_mask, w_sub, w_plen, w_lmask;

    // Mask is captured only on an accepted start; the start cycle itself uses the live input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mask <= '0;
        end else if (!i_hold && r_state == ST_IDLE && i_start) begin
            r_mask <= i_frozen_mask;
        end
    end

    assign w_mask      = (r_state == ST_IDLE) ? i_frozen_mask : r_mask;
    assign w_sub       = w_mask >> w_pi;
    assign w_plen      = N'(1) << w_ps;
    assign w_lmask     = (N'(1) << w_plen) - N'(1);
    assign w_sub_ones  = ((w_sub & w_lmask) == w_lmask);
    assign w_root_ones = &w_mask;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^i_frozen_mask;
    assign w_sub_ones    = 1'b0;
    assign w_root_ones   = 1'b0;
`endif

    // State register; hold has priority over every transition.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else if (!i_hold) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next tree position from the command currently on the outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_have      = 1'b0;
        w_pnew      = 1'b0;
        w_pend      = 1'b0;
        w_pi        = '0;
        w_ps        = '0;
        w_pf        = G_OP;
        w_pbcnt     = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_have      = 1'b1;
                    w_pnew      = 1'b1;
                    w_ps        = SW'(LOG_N - 1);
                    w_pf        = F_OP;
                end
            end
            ST_RUN: begin
                if (r_rate0_valid) begin
                    if (w_skip_end) begin
                        w_pend = 1'b1;
                    end else begin
                        w_have = 1'b1;
                        w_pnew = 1'b1;
                        w_pi   = w_skip_nxt[LOG_N-1:0];
                        w_ps   = w_ctz;
                        w_pf   = G_OP;
                    end
                end else if (!w_last_beat) begin
                    w_have  = 1'b1;
                    w_pi    = r_leaf_idx;
                    w_ps    = r_op_stage;
                    w_pf    = r_op_f;
                    w_pbcnt = r_bcnt + LOG_N'(1);
                end else if (r_op_stage != '0) begin
                    w_have = 1'b1;
                    w_pnew = 1'b1;
                    w_pi   = r_leaf_idx;
                    w_ps   = r_op_stage - SW'(1);
                    w_pf   = F_OP;
                end else if (r_leaf_idx == LAST_LEAF) begin
                    w_pend = 1'b1;
                end else begin
                    w_have = 1'b1;
                    w_pnew = 1'b1;
                    w_pi   = r_leaf_idx + LOG_N'(1);
                    w_ps   = w_ctz;
                    w_pf   = G_OP;
                end
                if (w_pend) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Turn the candidate into either a PE command or a frozen-subtree skip.
    always_comb begin
        w_skip     = 1'b0;
        w_skip_len = '0;
        if (w_have && w_pnew) begin
            if (r_state == ST_IDLE && w_root_ones) begin
                w_skip     = 1'b1;
                w_skip_len = N_FULL;
            end else if (w_sub_ones) begin
                w_skip     = 1'b1;
                w_skip_len = LEN_ONE << w_ps;
            end
        end
        w_op_valid_nxt   = w_have && !w_skip;
        w_op_f_nxt       = w_op_valid_nxt ? w_pf : 1'b0;
        w_op_stage_nxt   = w_op_valid_nxt ? w_ps : '0;
        w_op_node_nxt    = w_op_valid_nxt ? ((w_pi >> w_ps) >> 1) : '0;
        w_op_beat_nxt    = w_op_valid_nxt ? (w_pbcnt << LOG_P) : '0;
        w_leaf_valid_nxt = w_op_valid_nxt && (w_ps == '0);
        w_leaf_idx_nxt   = w_have ? w_pi : '0;
    end

    // Output/command registers; frozen while hold is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy        <= 1'b0;
            r_op_valid    <= 1'b0;
            r_op_f        <= 1'b0;
            r_op_stage    <= '0;
            r_op_node     <= '0;
            r_op_beat     <= '0;
            r_bcnt        <= '0;
            r_leaf_valid  <= 1'b0;
            r_leaf_idx    <= '0;
            r_rate0_valid <= 1'b0;
            r_rate0_len   <= '0;
            r_done        <= 1'b0;
        end else if (!i_hold) begin
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_op_valid    <= w_op_valid_nxt;
            r_op_f        <= w_op_f_nxt;
            r_op_stage    <= w_op_stage_nxt;
            r_op_node     <= w_op_node_nxt;
            r_op_beat     <= w_op_beat_nxt;
            r_bcnt        <= w_pbcnt;
            r_leaf_valid  <= w_leaf_valid_nxt;
            r_leaf_idx    <= w_leaf_idx_nxt;
            r_rate0_valid <= w_skip;
            r_rate0_len   <= w_skip_len;
            r_done        <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_busy        = r_busy;
    assign o_op_valid    = r_op_valid;
    assign o_op_f        = r_op_f;
    assign o_op_stage    = r_op_stage;
    assign o_op_node     = r_op_node;
    assign o_op_beat     = r_op_beat;
    assign o_leaf_valid  = r_leaf_valid;
    assign o_leaf_idx    = r_leaf_idx;
    assign o_rate0_valid = r_rate0_valid;
    assign o_rate0_len   = r_rate0_len;
    assign o_done        = r_done;

endmodule
